// File: rtl/mcr3_dl_pkg.sv
// Shared types and constants for the MCR3 Scroll ROM download router.
package mcr3_dl_pkg;

  // Default region boundaries and post-load reset hold.
  localparam logic [24:0] SP_BASE_DEF  = 25'h18000;
  localparam logic [24:0] BG_BASE_DEF  = 25'h28000;
  localparam logic [15:0] RST_HOLD_DEF = 16'hFFFF;

  // 8 KB blocks (ioctl_addr[24:13]) that also feed the sound dpram.
  localparam logic [11:0] SND_BLK_LO = 12'd7;
  localparam logic [11:0] SND_BLK_HI = 12'd8;

  // One buffered SDRAM byte write.
  typedef struct packed {
    logic        port;  // 0 = CPU/CSD port, 1 = sprite port
    logic [22:0] a;     // word address
    logic [1:0]  ds;    // byte select {hi,lo}
    logic [7:0]  d;     // byte, replicated onto both halves at issue
  } dl_entry_t;

  // Drain state machine.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } drain_state_t;

  // CSD byte-address swizzle: bit 14 rotates down to bit 0 and bits
  // 13:0 move up one place; bits 23:15 are unchanged.
  function automatic logic [23:0] csd_swizzle(input logic [23:0] addr);
    return {addr[23:16], addr[15], addr[13:0], addr[14]};
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous first-word-fall-through FIFO of download entries.
module dl_fifo
  import mcr3_dl_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        push_i,
  input  dl_entry_t   din_i,
  input  logic        pop_i,
  output dl_entry_t   dout_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] count_o
);

  localparam int DEPTH = 1 << AW;

  dl_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: reset is synchronous here, so RESET is sampled like any other input.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// Routes the HPS ioctl ROM download to SDRAM, sound dpram and the
// background loader; owns rom_loaded and core reset generation.
module rom_dl_router
  import mcr3_dl_pkg::*;
#(
  parameter int          FIFO_AW  = 2,
  parameter logic [24:0] SP_BASE  = SP_BASE_DEF,
  parameter logic [24:0] BG_BASE  = BG_BASE_DEF,
  parameter logic [15:0] RST_HOLD = RST_HOLD_DEF
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic        sdr_port,
  output logic [22:0] sdr_a,
  output logic [1:0]  sdr_ds,
  output logic [15:0] sdr_d,
  output logic        snd_we,
  output logic [13:0] snd_addr,
  output logic [7:0]  snd_d,
  output logic        bg_we,
  output logic [24:0] bg_addr,
  output logic [7:0]  bg_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  localparam int WAIT_LVL = (1 << FIFO_AW) - 1;

  // Write classification.
  logic        wr_ok;
  logic        in_main;
  logic        in_spr;
  logic        in_bg;
  logic        snd_hit;
  logic [23:0] wa;
  dl_entry_t   push_entry;

  // FIFO interface.
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FIFO_AW:0]   fifo_count;
  dl_entry_t          head;

  // Registered state.
  drain_state_t state_q;
  logic         sdr_req_q;
  logic         sdr_port_q;
  logic [22:0]  sdr_a_q;
  logic [1:0]   sdr_ds_q;
  logic [15:0]  sdr_d_q;
  logic         ioctl_wait_q;
  logic         overflow_q;
  logic         snd_we_q;
  logic [13:0]  snd_addr_q;
  logic [7:0]   snd_d_q;
  logic         bg_we_q;
  logic [24:0]  bg_addr_q;
  logic [7:0]   bg_d_q;
  logic         download_q;
  logic         pend_done_q;
  logic         rom_loaded_q;
  logic [15:0]  rst_cnt_q;
  logic         core_reset_q;
  logic         dl_fall;

  assign wr_ok   = ioctl_wr & ioctl_download & (ioctl_index == 8'd0);
  assign in_main = (ioctl_addr < SP_BASE);
  assign in_bg   = (ioctl_addr >= BG_BASE);
  assign in_spr  = ~in_main & ~in_bg;
  assign snd_hit = wr_ok & in_main &
                   ((ioctl_addr[24:13] == SND_BLK_LO) | (ioctl_addr[24:13] == SND_BLK_HI));

  assign fifo_push = wr_ok & ~in_bg;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;
  assign dl_fall   = download_q & ~ioctl_download & (ioctl_index == 8'd0);

  // Build the FIFO entry: region-relative byte address, CSD swizzle, byte lane.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wa = ioctl_addr[23:0];
    if (in_spr) begin
      wa = 24'(ioctl_addr - SP_BASE);
    end else if (in_main && ioctl_addr[16]) begin
      wa = csd_swizzle(ioctl_addr[23:0]);
    end
    push_entry.port = in_spr;
    push_entry.a    = wa[23:1];
    push_entry.ds   = {wa[0], ~wa[0]};
    push_entry.d    = ioctl_dout;
  end

  dl_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Flow control, overflow flag and the sound/background side strobes.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      ioctl_wait_q <= 1'b0;
      overflow_q   <= 1'b0;
      snd_we_q     <= 1'b0;
      snd_addr_q   <= '0;
      snd_d_q      <= '0;
      bg_we_q      <= 1'b0;
      bg_addr_q    <= '0;
      bg_d_q       <= '0;
    end else begin
      // Asserting one entry early leaves room for a write during the lag.
      ioctl_wait_q <= (fifo_count >= (FIFO_AW+1)'(WAIT_LVL));
      if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      snd_we_q <= snd_hit;
      if (snd_hit) begin
        snd_addr_q <= {~ioctl_addr[13], ioctl_addr[12:0]};
        snd_d_q    <= ioctl_dout;
      end
      bg_we_q <= wr_ok & in_bg;
      if (wr_ok && in_bg) begin
        bg_addr_q <= ioctl_addr - BG_BASE;
        bg_d_q    <= ioctl_dout;
      end
    end
  end

  // Drain FSM: load head, toggle request, hold outputs until acknowledged.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      sdr_req_q  <= sdr_ack;
      sdr_port_q <= 1'b0;
      sdr_a_q    <= '0;
      sdr_ds_q   <= '0;
      sdr_d_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            sdr_port_q <= head.port;
            sdr_a_q    <= head.a;
            sdr_ds_q   <= head.ds;
            sdr_d_q    <= {head.d, head.d};
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sdr_req_q <= ~sdr_req_q;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sdr_ack == sdr_req_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Load completion: wait for the download to end, then for the drain to finish.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      download_q   <= 1'b0;
      pend_done_q  <= 1'b0;
      rom_loaded_q <= 1'b0;
    end else begin
      download_q <= ioctl_download;
      if (dl_fall) pend_done_q <= 1'b1;
      if (pend_done_q && fifo_empty && state_q == ST_IDLE) begin
        rom_loaded_q <= 1'b1;
        pend_done_q  <= 1'b0;
      end
    end
  end

  // Core reset: held until loaded, then one extra pulse when the counter hits 1.
  always_ff @(posedge clk_sys) begin
    if (RESET || !rom_loaded_q) begin
      rst_cnt_q <= RST_HOLD;
    end else if (rst_cnt_q != 16'd0) begin
      rst_cnt_q <= rst_cnt_q - 16'd1;
    end
    core_reset_q <= RESET | ~rom_loaded_q | (rst_cnt_q == 16'd1);
  end

  assign ioctl_wait = ioctl_wait_q;
  assign sdr_req    = sdr_req_q;
  assign sdr_port   = sdr_port_q;
  assign sdr_a      = sdr_a_q;
  assign sdr_ds     = sdr_ds_q;
  assign sdr_d      = sdr_d_q;
  assign snd_we     = snd_we_q;
  assign snd_addr   = snd_addr_q;
  assign snd_d      = snd_d_q;
  assign bg_we      = bg_we_q;
  assign bg_addr    = bg_addr_q;
  assign bg_d       = bg_d_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router with an SDRAM toggle-ack responder.
module tb_rom_dl_router;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        sdr_ack;
  logic        ioctl_wait, sdr_req, sdr_port;
  logic [22:0] sdr_a;
  logic [1:0]  sdr_ds;
  logic [15:0] sdr_d;
  logic        snd_we;
  logic [13:0] snd_addr;
  logic [7:0]  snd_d;
  logic        bg_we;
  logic [24:0] bg_addr;
  logic [7:0]  bg_d;
  logic        rom_loaded, core_reset, overflow;

  int total = 0;
  int bad = 0;

  // Responder state: ack_allow is written by the stimulus only, the rest by the responder.
  int          ack_allow = 1000;
  int          acks_done = 0;
  logic        cap_port [64];
  logic [22:0] cap_a    [64];
  logic [1:0]  cap_ds   [64];
  logic [15:0] cap_d    [64];

  always #5 clk_sys = ~clk_sys;

  rom_dl_router dut (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .sdr_req        (sdr_req),
    .sdr_ack        (sdr_ack),
    .sdr_port       (sdr_port),
    .sdr_a          (sdr_a),
    .sdr_ds         (sdr_ds),
    .sdr_d          (sdr_d),
    .snd_we         (snd_we),
    .snd_addr       (snd_addr),
    .snd_d          (snd_d),
    .bg_we          (bg_we),
    .bg_addr        (bg_addr),
    .bg_d           (bg_d),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .overflow       (overflow)
  );

  // SDRAM model: captures each pending request and acknowledges it on a falling edge.
  initial begin
    sdr_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!RESET && (sdr_req !== sdr_ack) && (acks_done < ack_allow) && (acks_done < 64)) begin
        cap_port[acks_done] = sdr_port;
        cap_a[acks_done]    = sdr_a;
        cap_ds[acks_done]   = sdr_ds;
        cap_d[acks_done]    = sdr_d;
        acks_done++;
        sdr_ack = sdr_req;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One byte strobe; entered and left on a falling edge.
  task automatic put(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_acks(input int target, input string tag);
    int n = 0;
    while (acks_done < target && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(acks_done), 32'(target));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ioctl_wait && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic check_cap(input int idx, input logic port, input logic [22:0] a,
                           input logic [1:0] ds, input logic [15:0] d, input string tag);
    check(tag, {6'd0, cap_port[idx], cap_ds[idx], cap_a[idx]}, {6'd0, port, ds, a});
    check({tag, "_d"}, {16'd0, cap_d[idx]}, {16'd0, d});
  endtask

  initial begin
    int base;
    int n;
    logic req0;

    // Reset state.
    tick(3);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_wait",       {31'd0, ioctl_wait}, 32'd0);
    check("rst_snd_we",     {31'd0, snd_we},     32'd0);
    check("rst_bg_we",      {31'd0, bg_we},      32'd0);
    check("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    check("rst_overflow",   {31'd0, overflow},   32'd0);
    check("rst_req_ack",    {31'd0, sdr_req},    {31'd0, sdr_ack});
    check("rst_sdr_a",      {9'd0, sdr_a},       32'd0);
    RESET = 1'b0;
    ioctl_download = 1'b1;
    tick(2);

    // Plain CPU byte, odd address: word 1, high lane.
    base = acks_done;
    put(25'h0003, 8'h41);
    wait_acks(base + 1, "t1_ack");
    check_cap(base, 1'b0, 23'h000001, 2'b10, 16'h4141, "t1");

    // CSD swizzle: 0x10002 -> 0x10004 -> word 0x8002, low lane.
    base = acks_done;
    put(25'h10002, 8'h10);
    wait_acks(base + 1, "t2_ack");
    check_cap(base, 1'b0, 23'h008002, 2'b01, 16'h1010, "t2_csd");

    // CSD swizzle with bit 14 set: 0x14001 -> 0x10003 -> word 0x8001, high lane.
    base = acks_done;
    put(25'h14001, 8'h11);
    wait_acks(base + 1, "t2b_ack");
    check_cap(base, 1'b0, 23'h008001, 2'b10, 16'h1111, "t2b_csd");

    // Sound block 7: snd_addr = {~1, 0x0005} = 0x0005, plus SDRAM word 0x7002.
    base = acks_done;
    put(25'h0E005, 8'h20);
    check("t3_snd_we",   {31'd0, snd_we},    32'd1);
    check("t3_snd_addr", {18'd0, snd_addr},  32'h0005);
    check("t3_snd_d",    {24'd0, snd_d},     32'h20);
    tick(1);
    check("t3_snd_we_off", {31'd0, snd_we}, 32'd0);
    wait_acks(base + 1, "t3_ack");
    check_cap(base, 1'b0, 23'h007002, 2'b10, 16'h2020, "t3");

    // Sound block 8 (also CSD): snd_addr = {~0, 0} = 0x2000, word 0x8000.
    base = acks_done;
    put(25'h10000, 8'h33);
    check("t3b_snd_we",   {31'd0, snd_we},   32'd1);
    check("t3b_snd_addr", {18'd0, snd_addr}, 32'h2000);
    wait_acks(base + 1, "t3b_ack");
    check_cap(base, 1'b0, 23'h008000, 2'b01, 16'h3333, "t3b");

    // Sprite region start goes to port 2 at word 0.
    base = acks_done;
    put(25'h18000, 8'h55);
    wait_acks(base + 1, "t4_ack");
    check_cap(base, 1'b1, 23'h000000, 2'b01, 16'h5555, "t4_spr");

    // Background region: bg strobe only, no SDRAM request.
    req0 = sdr_req;
    put(25'h28010, 8'h66);
    check("t4_bg_we",   {31'd0, bg_we},   32'd1);
    check("t4_bg_addr", {7'd0, bg_addr},  32'h10);
    check("t4_bg_d",    {24'd0, bg_d},    32'h66);
    tick(1);
    check("t4_bg_we_off", {31'd0, bg_we}, 32'd0);
    tick(8);
    check("t4_no_req",  {31'd0, sdr_req}, {31'd0, req0});
    check("t4_no_ack",  32'(acks_done),   32'(base + 1));

    // Burst of 6 honouring ioctl_wait with acks held.
    ack_allow = acks_done;
    base = acks_done;
    for (int i = 0; i < 5; i++) begin
      wait_ready("t5_ready");
      put(25'h100 + 25'(i), 8'hA0 + 8'(i));
    end
    check("t5_wait_on", {31'd0, ioctl_wait}, 32'd1);
    check("t5_no_ovf",  {31'd0, overflow},   32'd0);
    tick(5);
    check("t5_wait_hold", {31'd0, ioctl_wait}, 32'd1);
    ack_allow = base + 100;
    wait_ready("t5_ready_last");
    put(25'h105, 8'hA5);
    wait_acks(base + 6, "t5_acks");
    for (int i = 0; i < 6; i++) begin
      check_cap(base + i, 1'b0, 23'h80 + 23'(i / 2), (i % 2 == 1) ? 2'b10 : 2'b01,
                {8'hA0 + 8'(i), 8'hA0 + 8'(i)}, $sformatf("t5_e%0d", i));
    end
    check("t5_no_ovf_end", {31'd0, overflow}, 32'd0);

    // Burst of 7 ignoring ioctl_wait: one in flight + 4 buffered, 2 dropped.
    ack_allow = acks_done;
    base = acks_done;
    for (int i = 0; i < 7; i++) put(25'h200 + 25'(i), 8'hB0 + 8'(i));
    check("t6_ovf", {31'd0, overflow}, 32'd1);
    ack_allow = base + 100;
    wait_acks(base + 5, "t6_acks");
    tick(20);
    check("t6_count", 32'(acks_done), 32'(base + 5));
    check_cap(base + 4, 1'b0, 23'h000102, 2'b01, 16'hB4B4, "t6_last");

    // End of download with two entries pending.
    ack_allow = acks_done;
    base = acks_done;
    put(25'h300, 8'hC0);
    put(25'h301, 8'hC1);
    ioctl_download = 1'b0;
    tick(10);
    check("t7_not_loaded0", {31'd0, rom_loaded}, 32'd0);
    check("t7_core_rst0",   {31'd0, core_reset}, 32'd1);
    ack_allow = base + 1;
    wait_acks(base + 1, "t7_ack1");
    tick(6);
    check("t7_not_loaded1", {31'd0, rom_loaded}, 32'd0);
    ack_allow = base + 2;
    wait_acks(base + 2, "t7_ack2");
    n = 0;
    while (!rom_loaded && n < 20) begin tick(1); n++; end
    check("t7_loaded", {31'd0, rom_loaded}, 32'd1);
    check_cap(base + 1, 1'b0, 23'h000180, 2'b10, 16'hC1C1, "t7_e1");
    n = 0;
    while (core_reset && n < 20) begin tick(1); n++; end
    check("t7_core_rst_fall", {31'd0, core_reset}, 32'd0);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!core_reset && n < 70000);
    check("t7_pulse_gap", 32'(n), 32'd65534);
    tick(1);
    check("t7_pulse_width", {31'd0, core_reset}, 32'd0);

    // Download restarted after load leaves rom_loaded and core_reset alone.
    ack_allow = acks_done + 100;
    ioctl_download = 1'b1;
    tick(1);
    base = acks_done;
    put(25'h400, 8'hD0);
    wait_acks(base + 1, "t8_ack");
    ioctl_download = 1'b0;
    tick(10);
    check("t8_loaded",   {31'd0, rom_loaded}, 32'd1);
    check("t8_core_rst", {31'd0, core_reset}, 32'd0);

    // RESET mid-drain: flush, abandon the request, clear rom_loaded.
    ioctl_download = 1'b1;
    ack_allow = acks_done;
    base = acks_done;
    put(25'h500, 8'hE0);
    put(25'h501, 8'hE1);
    put(25'h502, 8'hE2);
    tick(3);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("t9_req_ack",    {31'd0, sdr_req},    {31'd0, sdr_ack});
    check("t9_wait",       {31'd0, ioctl_wait}, 32'd0);
    check("t9_loaded",     {31'd0, rom_loaded}, 32'd0);
    check("t9_core_rst",   {31'd0, core_reset}, 32'd1);
    check("t9_ovf",        {31'd0, overflow},   32'd0);
    check("t9_sdr_a",      {9'd0, sdr_a},       32'd0);
    ack_allow = base + 100;
    tick(20);
    check("t9_flushed", 32'(acks_done), 32'(base));
    put(25'h601, 8'hE5);
    wait_acks(base + 1, "t9_restart_ack");
    check_cap(base, 1'b0, 23'h000300, 2'b10, 16'hE5E5, "t9_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
